// File: rtl/fog_loop_if.sv
// Control/data bundle between the loop sequencer and its neighbours
// (demodulator error path, modulation trigger, phase_ramp_gen drive).
interface fog_loop_if;
  logic               i_enable;
  logic               i_trig;
  logic signed [31:0] i_err;
  logic               i_err_vld;
  logic        [4:0]  i_gain_sh;
  logic        [31:0] i_step_max;
  logic        [15:0] i_settle_cnt;
  logic        [31:0] i_v2pi_init;
  logic signed [31:0] i_v2pi_err;
  logic               i_v2pi_vld;
  logic        [4:0]  i_v2pi_gain_sh;
  logic signed [31:0] o_step;
  logic        [31:0] o_v2pi;
  logic               o_fb_on;
  logic        [1:0]  o_state;
  logic               o_sat;

  modport master (
    output i_enable, i_trig, i_err, i_err_vld, i_gain_sh, i_step_max,
           i_settle_cnt, i_v2pi_init, i_v2pi_err, i_v2pi_vld, i_v2pi_gain_sh,
    input  o_step, o_v2pi, o_fb_on, o_state, o_sat
  );

  modport slave (
    input  i_enable, i_trig, i_err, i_err_vld, i_gain_sh, i_step_max,
           i_settle_cnt, i_v2pi_init, i_v2pi_err, i_v2pi_vld, i_v2pi_gain_sh,
    output o_step, o_v2pi, o_fb_on, o_state, o_sat
  );
endinterface

// File: rtl/fog_loop_ctrl.sv
// Closed-loop sequencer for the fibre-gyro feedback path.
// IDLE -> SETTLE -> LOCK sequencing, rate-error integration into the ramp
// step on each modulation trigger, and the secondary 2pi-voltage loop.
module fog_loop_ctrl #(
  parameter int unsigned SAT_LIMIT = 16,
  parameter logic [31:0] V2PI_MIN  = 32'd1000,
  parameter logic [31:0] V2PI_MAX  = 32'd30000
) (
  input logic       i_clk,
  input logic       i_rst_n,
  fog_loop_if.slave bus
);

  localparam int SAT_W = $clog2(SAT_LIMIT + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_LOCK   = 2'd2,
    ST_FAULT  = 2'd3
  } state_t;

  state_t             state;
  logic signed [31:0] step_p1;
  logic        [31:0] v2pi_p1;
  logic               fb_on_p1;
  logic               sat_p1;
  logic        [15:0] settle_cnt;
  logic [SAT_W-1:0]   sat_cnt;
  logic signed [31:0] err_pend_p0;
  logic               pend_vld_p0;

  logic signed [31:0] err_sh;
  logic signed [31:0] v2pi_err_sh;
  logic signed [32:0] step_sum;
  logic signed [32:0] v2pi_sum;
  logic signed [31:0] step_new;
  logic               step_hit;
  logic               step_upd;
  logic               settle_done;

  // Symmetric clamp of the integrated step; magnitude limited to what a
  // signed 32-bit step can represent.
  function automatic logic signed [31:0] sat_step(input logic signed [32:0] sum,
                                                  input logic [31:0] lim);
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    hi = lim[31] ? 33'sh0_7FFF_FFFF : $signed({1'b0, lim});
    lo = -hi;
    if (sum > hi) return hi[31:0];
    if (sum < lo) return lo[31:0];
    return sum[31:0];
  endfunction

  // Clamp of the 2pi voltage into its legal window.
  function automatic logic [31:0] sat_v2pi(input logic signed [32:0] sum);
    if (sum > $signed({1'b0, V2PI_MAX})) return V2PI_MAX;
    if (sum < $signed({1'b0, V2PI_MIN})) return V2PI_MIN;
    return sum[31:0];
  endfunction

  assign err_sh      = err_pend_p0 >>> bus.i_gain_sh;
  assign v2pi_err_sh = bus.i_v2pi_err >>> bus.i_v2pi_gain_sh;
  assign step_sum    = $signed({step_p1[31], step_p1}) + $signed({err_sh[31], err_sh});
  assign v2pi_sum    = $signed({1'b0, v2pi_p1}) + $signed({v2pi_err_sh[31], v2pi_err_sh});
  assign step_new    = sat_step(step_sum, bus.i_step_max);
  assign step_hit    = (step_sum != {step_new[31], step_new});
  assign step_upd    = (state == ST_LOCK) && bus.i_trig && pend_vld_p0;
  assign settle_done = (settle_cnt >= bus.i_settle_cnt) ||
                       (bus.i_trig && (({1'b0, settle_cnt} + 17'd1) >= {1'b0, bus.i_settle_cnt}));

  // Sequencer, error capture, step integrator and v2pi loop in one register stage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      step_p1     <= '0;
      v2pi_p1     <= '0;
      fb_on_p1    <= 1'b0;
      sat_p1      <= 1'b0;
      settle_cnt  <= '0;
      sat_cnt     <= '0;
      err_pend_p0 <= '0;
      pend_vld_p0 <= 1'b0;
    end else if (!bus.i_enable) begin
      state       <= ST_IDLE;
      step_p1     <= '0;
      fb_on_p1    <= 1'b0;
      sat_p1      <= 1'b0;
      settle_cnt  <= '0;
      sat_cnt     <= '0;
      pend_vld_p0 <= 1'b0;
    end else begin
      // A trigger consumes the old pending error; a coincident new one stays pending.
      if (bus.i_err_vld) err_pend_p0 <= bus.i_err;
      pend_vld_p0 <= bus.i_err_vld | (pend_vld_p0 & ~step_upd);

      unique case (state)
        ST_IDLE: begin
          state      <= ST_SETTLE;
          v2pi_p1    <= bus.i_v2pi_init;
          settle_cnt <= '0;
          sat_cnt    <= '0;
          sat_p1     <= 1'b0;
          step_p1    <= '0;
          fb_on_p1   <= 1'b0;
        end
        ST_SETTLE: begin
          if (settle_done) begin
            state    <= ST_LOCK;
            fb_on_p1 <= 1'b1;
          end else if (bus.i_trig) begin
            settle_cnt <= settle_cnt + 16'd1;
          end
        end
        ST_LOCK: begin
          if (step_upd) begin
            sat_p1 <= step_hit;
            if (!step_hit) begin
              sat_cnt <= '0;
              step_p1 <= step_new;
            end else if (sat_cnt >= SAT_W'(SAT_LIMIT - 1)) begin
              state    <= ST_FAULT;
              step_p1  <= '0;
              fb_on_p1 <= 1'b0;
            end else begin
              sat_cnt <= sat_cnt + SAT_W'(1);
              step_p1 <= step_new;
            end
          end
          if (bus.i_v2pi_vld) v2pi_p1 <= sat_v2pi(v2pi_sum);
        end
        ST_FAULT: begin
          step_p1  <= '0;
          fb_on_p1 <= 1'b0;
          sat_p1   <= 1'b1;
        end
      endcase
    end
  end

  assign bus.o_step  = step_p1;
  assign bus.o_v2pi  = v2pi_p1;
  assign bus.o_fb_on = fb_on_p1;
  assign bus.o_state = state;
  assign bus.o_sat   = sat_p1;

endmodule

// File: tb/tb_fog_loop_ctrl.sv
// Directed bench for fog_loop_ctrl: table of step-integration vectors plus
// hand sequences for settle, v2pi clamping, fault and async reset.
module tb_fog_loop_ctrl;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  fog_loop_if bus();

  fog_loop_ctrl dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit do_err;
    int err;
    int gain;
    int step_max;
    int exp_step;
    bit exp_sat;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_err(input int e, input int sh);
    bus.i_err     = e;
    bus.i_gain_sh = 5'(sh);
    bus.i_err_vld = 1'b1;
    tick();
    bus.i_err_vld = 1'b0;
  endtask

  task automatic pulse_trig();
    bus.i_trig = 1'b1;
    tick();
    bus.i_trig = 1'b0;
  endtask

  task automatic pulse_v2pi(input int e, input int sh);
    bus.i_v2pi_err     = e;
    bus.i_v2pi_gain_sh = 5'(sh);
    bus.i_v2pi_vld     = 1'b1;
    tick();
    bus.i_v2pi_vld     = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{1'b1,   4800, 2, 100000,  1200, 1'b0};
    vecs[1] = '{1'b1,   4800, 2, 100000,  2400, 1'b0};
    vecs[2] = '{1'b1,   4800, 2, 100000,  3600, 1'b0};
    vecs[3] = '{1'b0,      0, 2, 100000,  3600, 1'b0};
    vecs[4] = '{1'b1,   8000, 0,   2000,  2000, 1'b1};
    vecs[5] = '{1'b1, -16000, 0,   2000, -2000, 1'b1};
    vecs[6] = '{1'b1,    100, 0,   2000, -1900, 1'b0};

    rst_n              = 1'b0;
    bus.i_enable       = 1'b0;
    bus.i_trig         = 1'b0;
    bus.i_err          = 0;
    bus.i_err_vld      = 1'b0;
    bus.i_gain_sh      = 5'd0;
    bus.i_step_max     = 32'd100000;
    bus.i_settle_cnt   = 16'd4;
    bus.i_v2pi_init    = 32'd8000;
    bus.i_v2pi_err     = 0;
    bus.i_v2pi_vld     = 1'b0;
    bus.i_v2pi_gain_sh = 5'd0;

    repeat (3) tick();
    chk("reset_state", int'(bus.o_state), 0);
    chk("reset_step",  bus.o_step, 0);
    chk("reset_v2pi",  int'(bus.o_v2pi), 0);
    chk("reset_fb_on", int'(bus.o_fb_on), 0);
    chk("reset_sat",   int'(bus.o_sat), 0);

    // Settle: four triggers 100 clocks apart
    rst_n = 1'b1;
    tick();
    bus.i_enable = 1'b1;
    tick();
    chk("settle_entry_state", int'(bus.o_state), 1);
    chk("settle_v2pi_init",   int'(bus.o_v2pi), 8000);
    chk("settle_fb_off",      int'(bus.o_fb_on), 0);
    for (int t = 0; t < 3; t++) begin
      repeat (99) tick();
      pulse_trig();
    end
    chk("settle_after3_state", int'(bus.o_state), 1);
    pulse_v2pi(400, 0);
    chk("settle_v2pi_ignored", int'(bus.o_v2pi), 8000);
    repeat (98) tick();
    pulse_trig();
    chk("lock_state", int'(bus.o_state), 2);
    chk("lock_fb_on", int'(bus.o_fb_on), 1);

    // v2pi loop
    pulse_v2pi(400, 2);
    chk("v2pi_step", int'(bus.o_v2pi), 8100);
    pulse_v2pi(-40000, 0);
    chk("v2pi_min_clamp", int'(bus.o_v2pi), 1000);

    // Step integration table
    for (int i = 0; i < 7; i++) begin
      bus.i_step_max = 32'(vecs[i].step_max);
      if (vecs[i].do_err) pulse_err(vecs[i].err, vecs[i].gain);
      tick();
      pulse_trig();
      chk($sformatf("vec%0d_step", i), bus.o_step, vecs[i].exp_step);
      chk($sformatf("vec%0d_sat", i), int'(bus.o_sat), int'(vecs[i].exp_sat));
    end

    // Coincident error and trigger with nothing pending
    bus.i_err     = 400;
    bus.i_gain_sh = 5'd2;
    bus.i_err_vld = 1'b1;
    bus.i_trig    = 1'b1;
    tick();
    bus.i_err_vld = 1'b0;
    bus.i_trig    = 1'b0;
    chk("coinc_step_held", bus.o_step, -1900);
    tick();
    pulse_trig();
    chk("coinc_next_trig", bus.o_step, -1800);
    chk("coinc_next_sat",  int'(bus.o_sat), 0);

    // Sustained saturation into FAULT
    for (int i = 1; i <= 16; i++) begin
      pulse_err(8000, 0);
      pulse_trig();
      if (i == 15) begin
        chk("sat15_state", int'(bus.o_state), 2);
        chk("sat15_step",  bus.o_step, 2000);
        chk("sat15_sat",   int'(bus.o_sat), 1);
      end
    end
    chk("fault_state", int'(bus.o_state), 3);
    chk("fault_fb_on", int'(bus.o_fb_on), 0);
    chk("fault_step",  bus.o_step, 0);
    chk("fault_sat",   int'(bus.o_sat), 1);
    chk("fault_v2pi_held", int'(bus.o_v2pi), 1000);
    tick();
    chk("fault_sticky", int'(bus.o_state), 3);

    bus.i_enable = 1'b0;
    tick();
    chk("disable_idle", int'(bus.o_state), 0);
    chk("disable_step", bus.o_step, 0);

    // Re-enable with zero settle count
    bus.i_settle_cnt = 16'd0;
    bus.i_enable     = 1'b1;
    tick();
    chk("reenable_settle", int'(bus.o_state), 1);
    tick();
    chk("settle0_lock", int'(bus.o_state), 2);
    pulse_err(400, 0);
    pulse_trig();
    chk("relock_step", bus.o_step, 400);
    chk("relock_v2pi", int'(bus.o_v2pi), 8000);

    // Asynchronous reset between clock edges
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_state", int'(bus.o_state), 0);
    chk("async_rst_step",  bus.o_step, 0);
    chk("async_rst_v2pi",  int'(bus.o_v2pi), 0);
    chk("async_rst_fb_on", int'(bus.o_fb_on), 0);
    chk("async_rst_sat",   int'(bus.o_sat), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fog_loop_ctrl.md
Name: fog_loop_ctrl

Overview:
- Closed-loop sequencer for the fibre-gyro feedback path: drives i_step, i_v2pi and i_fb_on of phase_ramp_gen.
- Steps an IDLE -> SETTLE -> LOCK sequence, integrates the demodulated rate error into the ramp step on each modulation step trigger, and runs the secondary 2π-voltage loop.
- Sits between the demodulator/error logic and phase_ramp_gen; its i_trig is the o_stepTrig of modulation_gen_v2.

Parameters:
- SAT_LIMIT, 16, consecutive saturated step updates in LOCK that force FAULT.
- V2PI_MIN, 32'd1000, lower clamp for o_v2pi.
- V2PI_MAX, 32'd30000, upper clamp for o_v2pi.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  reset; asynchronous assert, active-low.
- i_enable  in  1  level; high requests loop operation, low returns to IDLE.
- i_trig  in  1  one-cycle step trigger from modulation_gen_v2.
- i_err  in  32  signed rate error, valid with i_err_vld.
- i_err_vld  in  1  one-cycle qualifier for i_err.
- i_gain_sh  in  5  arithmetic right-shift applied to the error (0..31).
- i_step_max  in  32  unsigned magnitude limit for o_step; must be >0.
- i_settle_cnt  in  16  number of i_trig pulses spent in SETTLE.
- i_v2pi_init  in  32  o_v2pi load value on entry to SETTLE.
- i_v2pi_err  in  32  signed 2π error, valid with i_v2pi_vld.
- i_v2pi_vld  in  1  one-cycle qualifier for i_v2pi_err.
- i_v2pi_gain_sh  in  5  right-shift for the v2pi error.
- o_step  out  32  signed ramp step to phase_ramp_gen.i_step.
- o_v2pi  out  32  2π voltage to phase_ramp_gen.i_v2pi.
- o_fb_on  out  1  to phase_ramp_gen.i_fb_on.
- o_state  out  2  0=IDLE, 1=SETTLE, 2=LOCK, 3=FAULT.
- o_sat  out  1  high while the last step update clamped.

Behaviour:
- Reset (async, i_rst_n=0): state IDLE, o_step=0, o_v2pi=0, o_fb_on=0, o_sat=0, settle counter=0, sat counter=0, pending-error flag cleared. All outputs are registered.
- IDLE: o_fb_on=0, o_step=0. On i_enable=1, go to SETTLE next cycle, load o_v2pi<=i_v2pi_init, and clear the settle counter.
- SETTLE: o_fb_on=0. Count i_trig pulses. When the count reaches i_settle_cnt, go to LOCK on the following cycle. i_settle_cnt=0 leaves SETTLE on the cycle after entry.
- LOCK: o_fb_on=1, starting the first cycle in LOCK.
- Error capture: i_err_vld latches i_err into the pending register and sets the pending flag. A later vld overwrites it (last-wins).
- Step update: on i_trig with pending=1:
  - sum = sext33(o_step) + sext33(i_err >>> i_gain_sh);
  - clamp sum to [-i_step_max, +i_step_max] and register it into o_step one cycle after i_trig;
  - clear pending;
  - o_sat = 1 if clamped, else 0.
- Trigger with no pending error: i_trig with pending=0 leaves o_step and o_sat unchanged.
- Simultaneous i_err_vld and i_trig: the trig consumes the previously pending value (if any). The new error becomes pending for the next trig.
- Saturation counter: increments on each clamped update and clears on any unclamped update. Reaching SAT_LIMIT sends the block to FAULT.
- v2pi loop (LOCK only): on i_v2pi_vld, o_v2pi <= clamp(o_v2pi + (i_v2pi_err >>> i_v2pi_gain_sh), V2PI_MIN, V2PI_MAX), computed in 33-bit signed, latency 1. Ignored in other states.
- FAULT: o_fb_on=0, o_step=0, o_sat=1, o_v2pi held. Exit only via i_enable=0 -> IDLE.
- i_enable=0 in any state: next cycle IDLE, o_fb_on=0, o_step=0, pending cleared. This takes priority over all other events in that cycle.
- Reset asserted mid-operation: immediate return to reset values regardless of state.

Test Plan:
- Reset, i_enable=1, i_settle_cnt=4, trig every 100 clk -> o_state 1 after 1 clk; o_state 2 and o_fb_on=1 one cycle after the 4th trig; o_v2pi=i_v2pi_init.
- LOCK, gain_sh=2, err=+4800 vld then trig, repeated 3x -> o_step 1200, 2400, 3600, each 1 clk after trig. A trig with no new err leaves o_step=3600.
- i_step_max=2000, err=+8000, gain 0 -> o_step=2000, o_sat=1. Then err=-16000 -> o_step=-2000. Then err=+100 -> o_step=-1900, o_sat=0.
- SAT_LIMIT=16: keep clamping for 16 trigs -> o_state=3, o_fb_on=0, o_step=0. Then i_enable=0 -> o_state=0. Then i_enable=1 -> SETTLE again.
- v2pi: init 8000, v2pi_err=+400 shift 2 -> 8100. Then err=-40000 shift 0 -> 1000 (V2PI_MIN). A v2pi_vld pulse in SETTLE leaves o_v2pi unchanged.
- err_vld coincident with trig (pending=0) -> o_step unchanged; next trig applies that error. i_rst_n pulsed low in LOCK -> all outputs 0 asynchronously.
